// File: rtl/nubus_mem_arbiter.sv
// Two-port round-robin arbiter and sequencer for a single-port word memory.
// Port 0 is the NuBus slave path, port 1 the local CPU/DMA path.
module nubus_mem_arbiter #(
    parameter int TIMEOUT_CLOCKS = 16,
    parameter int CNT_W          = 8
) (
    input  logic        mem_clk,
    input  logic        mem_resetn,
    input  logic        m0_valid,
    input  logic [3:0]  m0_wstrb,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_ready,
    output logic        m0_err,
    input  logic        m1_valid,
    input  logic [3:0]  m1_wstrb,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_ready,
    output logic        m1_err,
    output logic        mem_valid_o,
    output logic [3:0]  mem_wstrb_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ready_i,
    output logic        grant_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CLOCKS - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             grant_q, grant_d;
    logic             valid_q, valid_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata0_q, rdata0_d;
    logic [31:0]      rdata1_q, rdata1_d;
    logic [1:0]       ready_q, ready_d;
    logic [1:0]       err_q, err_d;
    logic             sel;

    // Next-state logic: arbitrate in IDLE, wait or time out in ACCESS,
    // recover for one cycle in DONE.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        grant_d  = grant_q;
        valid_d  = valid_q;
        wstrb_d  = wstrb_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        ready_d  = 2'b00;
        err_d    = 2'b00;
        sel      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (m0_valid || m1_valid) begin
                    // Tie goes to the port that was not served last.
                    sel     = (m0_valid && m1_valid) ? ~grant_q : m1_valid;
                    grant_d = sel;
                    valid_d = 1'b1;
                    wstrb_d = sel ? m1_wstrb : m0_wstrb;
                    addr_d  = sel ? m1_addr  : m0_addr;
                    wdata_d = sel ? m1_wdata : m0_wdata;
                    cnt_d   = '0;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (mem_ready_i) begin
                    // Read data is only trusted on an acknowledged read.
                    if (wstrb_q == 4'b0000) begin
                        if (grant_q) begin
                            rdata1_d = mem_rdata_i;
                        end else begin
                            rdata0_d = mem_rdata_i;
                        end
                    end
                    valid_d = 1'b0;
                    wstrb_d = 4'b0000;
                    ready_d = grant_q ? 2'b10 : 2'b01;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    if (grant_q) begin
                        rdata1_d = '0;
                    end else begin
                        rdata0_d = '0;
                    end
                    valid_d = 1'b0;
                    wstrb_d = 4'b0000;
                    ready_d = grant_q ? 2'b10 : 2'b01;
                    err_d   = grant_q ? 2'b10 : 2'b01;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; async reset aborts any transfer silently.
    always_ff @(posedge mem_clk or negedge mem_resetn) begin
        if (!mem_resetn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            grant_q  <= 1'b1;
            valid_q  <= 1'b0;
            wstrb_q  <= 4'b0000;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            ready_q  <= 2'b00;
            err_q    <= 2'b00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            valid_q  <= valid_d;
            wstrb_q  <= wstrb_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
        end
    end

    assign mem_valid_o = valid_q;
    assign mem_wstrb_o = wstrb_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign m0_rdata    = rdata0_q;
    assign m1_rdata    = rdata1_q;
    assign m0_ready    = ready_q[0];
    assign m1_ready    = ready_q[1];
    assign m0_err      = err_q[0];
    assign m1_err      = err_q[1];
    assign grant_o     = grant_q;

endmodule

// File: tb/tb_nubus_mem_arbiter.sv
// Bench for nubus_mem_arbiter: directed vector table, corner-case
// sequences and a randomized run against a shadow-memory model.
module tb_nubus_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_valid = 1'b0, m1_valid = 1'b0;
    logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
    logic [31:0] m0_addr = '0, m1_addr = '0;
    logic [31:0] m0_wdata = '0, m1_wdata = '0;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ready, m1_ready, m0_err, m1_err;
    logic        mem_valid_o;
    logic [3:0]  mem_wstrb_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic        mem_ready_i;
    logic        grant_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nubus_mem_arbiter #(.TIMEOUT_CLOCKS(16), .CNT_W(8)) dut (
        .mem_clk(clk), .mem_resetn(rst_n),
        .m0_valid(m0_valid), .m0_wstrb(m0_wstrb), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ready(m0_ready),
        .m0_err(m0_err),
        .m1_valid(m1_valid), .m1_wstrb(m1_wstrb), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ready(m1_ready),
        .m1_err(m1_err),
        .mem_valid_o(mem_valid_o), .mem_wstrb_o(mem_wstrb_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i),
        .grant_o(grant_o)
    );

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] d,
                                          input logic [3:0] ws);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (ws[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Memory: acks after wait_states cycles of valid, counter restarts
    // only when valid drops; rdata bus carries junk except on read acks.
    logic [31:0] memory [0:63] = '{default: 32'h0};
    int wcnt = 0;
    int wait_states = 0;
    logic hang = 1'b0;

    assign mem_ready_i = mem_valid_o && !hang && (wcnt == wait_states);
    assign mem_rdata_i = (mem_ready_i && mem_wstrb_o == 4'b0000)
                       ? memory[mem_addr_o[7:2]] : 32'hBAD0BAD0;

    always @(posedge clk) begin
        if (!mem_valid_o) wcnt <= 0;
        else if (!mem_ready_i) wcnt <= wcnt + 1;
        if (mem_ready_i && mem_wstrb_o != 4'b0000)
            memory[mem_addr_o[7:2]] <= merge(memory[mem_addr_o[7:2]],
                                             mem_wdata_o, mem_wstrb_o);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int p, input logic v, input logic [3:0] ws,
                         input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            m0_valid = v; m0_wstrb = ws; m0_addr = a; m0_wdata = d;
        end else begin
            m1_valid = v; m1_wstrb = ws; m1_addr = a; m1_wdata = d;
        end
    endtask

    function automatic logic rdy(input int p);
        return (p == 0) ? m0_ready : m1_ready;
    endfunction

    function automatic logic vld(input int p);
        return (p == 0) ? m0_valid : m1_valid;
    endfunction

    function automatic logic [31:0] rdat(input int p);
        return (p == 0) ? m0_rdata : m1_rdata;
    endfunction

    function automatic logic erf(input int p);
        return (p == 0) ? m0_err : m1_err;
    endfunction

    // One transfer from an idle-state negedge; lat counts negedges to ready.
    task automatic xfer(input int p, input logic [3:0] ws,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er,
                        output int lat, output logic oth);
        drive(p, 1'b1, ws, a, d);
        lat = 0; rd = '0; er = 1'b0; oth = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            if (rdy(p)) begin
                lat = k; rd = rdat(p); er = erf(p);
                oth = rdy(1 - p) | erf(1 - p);
                break;
            end
        end
        drive(p, 1'b0, ws, a, d);
        @(negedge clk);
        if (lat == 0) begin
            checks++; errors++;
            $display("FAIL xfer_timeout: port %0d got no ready", p);
        end
    endtask

    typedef struct {
        int          p;
        logic [3:0]  ws;
        logic [31:0] a;
        logic [31:0] d;
        int          w;
        logic [31:0] exp_rd;
        int          exp_lat;
    } vec_t;

    initial begin
        vec_t        vt [11];
        logic [31:0] last_rd [2];
        logic [31:0] exp_rd [2];
        logic        is_rd [2];
        logic [31:0] shadow [0:63];
        int          issued [2];
        int          done [2];
        logic [31:0] rd, a0, e;
        logic        er, oth, stable, seen;
        int          lat, nrdy, lastc, gcyc, gw;
        logic        g, expg, prev_g, vprev;
        logic [1:0]  req_prev;
        logic [3:0]  ws;
        logic [31:0] a, d;
        int          k;

        vt[0]  = '{0, 4'hF, 32'h10, 32'hDEADBEEF, 0, 32'h0, 2};
        vt[1]  = '{0, 4'h0, 32'h10, 32'h0, 0, 32'hDEADBEEF, 2};
        vt[2]  = '{1, 4'hF, 32'h20, 32'hAABBCCDD, 0, 32'h0, 2};
        vt[3]  = '{1, 4'h1, 32'h20, 32'h00000055, 0, 32'h0, 2};
        vt[4]  = '{1, 4'h0, 32'h20, 32'h0, 0, 32'hAABBCC55, 2};
        vt[5]  = '{1, 4'hF, 32'h24, 32'hCAFEF00D, 1, 32'h0, 3};
        vt[6]  = '{1, 4'hC, 32'h24, 32'h12345678, 2, 32'h0, 4};
        vt[7]  = '{0, 4'h0, 32'h24, 32'h0, 0, 32'h1234F00D, 2};
        vt[8]  = '{0, 4'h0, 32'h10, 32'h0, 3, 32'hDEADBEEF, 5};
        vt[9]  = '{1, 4'h6, 32'h20, 32'h00C3C300, 0, 32'h0, 2};
        vt[10] = '{1, 4'h0, 32'h20, 32'h0, 1, 32'hAAC3C355, 3};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(mem_valid_o), 32'h0);
        chk("rst_membus", mem_addr_o | mem_wdata_o | 32'(mem_wstrb_o), 32'h0);
        chk("rst_rdata", m0_rdata | m1_rdata, 32'h0);
        chk("rst_rdy_err", 32'({m0_ready, m1_ready, m0_err, m1_err}), 32'h0);
        chk("rst_grant", 32'(grant_o), 32'h1);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vector table
        last_rd[0] = '0; last_rd[1] = '0;
        for (int i = 0; i < 11; i++) begin
            wait_states = vt[i].w;
            xfer(vt[i].p, vt[i].ws, vt[i].a, vt[i].d, rd, er, lat, oth);
            e = (vt[i].ws == 4'h0) ? vt[i].exp_rd : last_rd[vt[i].p];
            chk($sformatf("vec%0d_rdata", i), rd, e);
            chk($sformatf("vec%0d_err", i), 32'(er), 32'h0);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vt[i].exp_lat));
            chk($sformatf("vec%0d_other", i), 32'(oth), 32'h0);
            last_rd[vt[i].p] = e;
        end
        wait_states = 0;

        // Timeout on port 1, then normal service on port 0
        hang = 1'b1;
        xfer(1, 4'h0, 32'h20, 32'h0, rd, er, lat, oth);
        chk("to_lat", 32'(lat), 32'd17);
        chk("to_err", 32'(er), 32'h1);
        chk("to_rdata", rd, 32'h0);
        chk("to_other", 32'(oth), 32'h0);
        hang = 1'b0;
        xfer(0, 4'h0, 32'h10, 32'h0, rd, er, lat, oth);
        chk("after_to_rdata", rd, 32'hDEADBEEF);
        chk("after_to_err", 32'(er), 32'h0);
        chk("after_to_lat", 32'(lat), 32'd2);

        // W=3 read on port 0 while port 1 toggles during ACCESS
        wait_states = 3;
        drive(0, 1'b1, 4'h0, 32'h10, 32'h0);
        @(negedge clk);
        chk("w3_valid", 32'(mem_valid_o), 32'h1);
        a0 = mem_addr_o;
        lat = 0; stable = 1'b1; seen = 1'b0;
        for (int j = 2; j <= 30; j++) begin
            m1_valid = ~m1_valid;
            m1_addr = $urandom;
            m1_wstrb = 4'($urandom_range(0, 15));
            @(negedge clk);
            if (m1_ready) seen = 1'b1;
            if (m0_ready) begin
                lat = j;
                break;
            end
            if (!mem_valid_o || mem_addr_o != a0) stable = 1'b0;
        end
        m1_valid = 1'b0;
        drive(0, 1'b0, 4'h0, 32'h10, 32'h0);
        @(negedge clk);
        chk("w3_lat", 32'(lat), 32'd5);
        chk("w3_stable", 32'(stable), 32'h1);
        chk("w3_rdata", m0_rdata, 32'hDEADBEEF);
        chk("w3_no_m1", 32'(seen), 32'h0);

        // Reset two cycles into a W=3 access
        drive(0, 1'b1, 4'h0, 32'h10, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(mem_valid_o), 32'h0);
        drive(0, 1'b0, 4'h0, 32'h10, 32'h0);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (m0_ready || m0_err) seen = 1'b1;
        end
        chk("midrst_no_ready", 32'(seen), 32'h0);
        wait_states = 0;
        rst_n = 1'b1;

        // Both ports held for four transfers: grants alternate 0,1,0,1
        drive(0, 1'b1, 4'hF, 32'h0, 32'h11111111);
        drive(1, 1'b1, 4'hF, 32'h4, 32'h22222222);
        @(negedge clk);
        chk("rr_first_valid", 32'(mem_valid_o), 32'h1);
        chk("rr_first_grant", 32'(grant_o), 32'h0);
        chk("rr_first_addr", mem_addr_o, 32'h0);
        nrdy = 0; lastc = 0;
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            if (m0_ready && m1_ready)
                chk("rr_coincide", 32'h1, 32'h0);
            if (m0_ready || m1_ready) begin
                chk($sformatf("rr%0d_port", nrdy), 32'(m1_ready),
                    32'(nrdy % 2));
                chk($sformatf("rr%0d_gap", nrdy), 32'(mem_valid_o), 32'h0);
                if (nrdy > 0)
                    chk($sformatf("rr%0d_spacing", nrdy), 32'(j - lastc),
                        32'd3);
                lastc = j;
                nrdy++;
                if (nrdy == 4) begin
                    m0_valid = 1'b0;
                    m1_valid = 1'b0;
                    break;
                end
            end
        end
        chk("rr_count", 32'(nrdy), 32'd4);
        @(negedge clk);
        xfer(1, 4'h0, 32'h4, 32'h0, rd, er, lat, oth);
        chk("rr_rb1", rd, 32'h22222222);
        xfer(0, 4'h0, 32'h0, 32'h0, rd, er, lat, oth);
        chk("rr_rb0", rd, 32'h11111111);

        // Randomized traffic against a shadow memory
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 64; i++) shadow[i] = memory[i];
        for (int p = 0; p < 2; p++) begin
            last_rd[p] = '0; exp_rd[p] = '0; is_rd[p] = 1'b0;
            issued[p] = 0; done[p] = 0;
        end
        prev_g = 1'b1; vprev = 1'b0; req_prev = 2'b00;
        gcyc = 0; gw = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (mem_valid_o && !vprev) begin
                g = mem_addr_o[7];
                expg = (req_prev == 2'b11) ? ~prev_g : req_prev[1];
                chk("rnd_grant", 32'(g), 32'(expg));
                chk("rnd_grant_o", 32'(grant_o), 32'(g));
                prev_g = g; gcyc = cyc; gw = wait_states;
            end
            vprev = mem_valid_o;
            if (m0_ready && m1_ready) chk("rnd_coincide", 32'h1, 32'h0);
            if (!mem_valid_o && mem_wstrb_o != 4'h0)
                chk("rnd_wstrb_idle", 32'(mem_wstrb_o), 32'h0);
            for (int p = 0; p < 2; p++) begin
                if (vld(p) && rdy(p)) begin
                    chk("rnd_rdata", rdat(p), exp_rd[p]);
                    chk("rnd_err", 32'(erf(p)), 32'h0);
                    chk("rnd_lat", 32'(cyc - gcyc), 32'(gw + 1));
                    if (is_rd[p]) last_rd[p] = exp_rd[p];
                    done[p]++;
                    drive(p, 1'b0, 4'h0, 32'h0, 32'h0);
                end
                if (!vld(p) && issued[p] < 30 && $urandom_range(0, 2) != 0) begin
                    k = int'($urandom_range(0, 15));
                    ws = ($urandom_range(0, 2) == 0)
                       ? 4'h0 : 4'($urandom_range(1, 15));
                    a = ((p == 0) ? 32'h40 : 32'h80) + 32'(k * 4);
                    d = $urandom;
                    if (ws == 4'h0) begin
                        exp_rd[p] = shadow[a[7:2]];
                    end else begin
                        shadow[a[7:2]] = merge(shadow[a[7:2]], d, ws);
                        exp_rd[p] = last_rd[p];
                    end
                    is_rd[p] = (ws == 4'h0);
                    drive(p, 1'b1, ws, a, d);
                    issued[p]++;
                end
            end
            if (!mem_valid_o) wait_states = int'($urandom_range(0, 3));
            req_prev = {m1_valid, m0_valid};
            if (done[0] == 30 && done[1] == 30) break;
        end
        chk("rnd_done0", 32'(done[0]), 32'd30);
        chk("rnd_done1", 32'(done[1]), 32'd30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
